// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus around one elastic pipeline register: upstream (in_*) and downstream (out_*) sides.
// The register uses the slave modport; whoever drives the inputs and consumes the output uses master.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, bubble collapsing and flush.
// Optional occupancy counter port enabled by defining PIPE_STAGE_REG_OCC_EN.
module pipe_stage_reg #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
`ifdef PIPE_STAGE_REG_OCC_EN
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
`endif
   pipe_stage_reg_if.slave            bus
);

   logic [DEPTH-1:0] r_vld;
   logic [WIDTH-1:0] r_data [DEPTH];

   logic [DEPTH:0]   w_rdy;
   logic [DEPTH-1:0] w_src_vld;
   logic [WIDTH-1:0] w_src_data [DEPTH];

   // Ready ripples backwards: any empty stage lets everything upstream of it advance.
   always_comb begin
      w_rdy        = '0;
      w_rdy[DEPTH] = bus.out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_rdy[i] = !r_vld[i] || w_rdy[i+1];
      end
   end

   always_comb begin
      w_src_vld     = '0;
      w_src_vld[0]  = bus.in_valid;
      w_src_data[0] = bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
         w_src_vld[i]  = r_vld[i-1];
         w_src_data[i] = r_data[i-1];
      end
   end

   // Stage registers: valid bits are cleared by flush, data only moves with a valid payload.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
               r_vld[i] <= 1'b0;
            end else if (w_rdy[i]) begin
               r_vld[i] <= w_src_vld[i];
               if (w_src_vld[i]) begin
                  r_data[i] <= w_src_data[i];
               end
            end
         end
      end
   end

   assign bus.in_ready  = w_rdy[0];
   assign bus.out_valid = r_vld[DEPTH-1];
   assign bus.out_data  = r_data[DEPTH-1];

`ifdef PIPE_STAGE_REG_OCC_EN
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [OCC_W-1:0] r_occ;
   logic             w_in_xfer;
   logic             w_out_xfer;

   assign w_in_xfer  = bus.in_valid && w_rdy[0];
   assign w_out_xfer = r_vld[DEPTH-1] && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_occ <= '0;
      end else begin
         r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
      end
   end

   assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector table plus random scoreboard run for pipe_stage_reg (DEPTH=3, RESET_VAL=0xCAFE).
module tb_pipe_stage_reg;
   localparam int               WIDTH = 16;
   localparam int               DEPTH = 3;
   localparam logic [WIDTH-1:0] RV    = 16'hCAFE;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   pipe_stage_reg_if #(.WIDTH(WIDTH)) bus ();

`ifdef PIPE_STAGE_REG_OCC_EN
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

   pipe_stage_reg #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
`ifdef PIPE_STAGE_REG_OCC_EN
      .occupancy(occupancy),
`endif
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic             rst;
      logic             iv;
      logic [WIDTH-1:0] din;
      logic             orr;
      logic             fl;
      logic             e_rdy;
      logic             e_ov;
      logic [WIDTH-1:0] e_od;
      int               e_occ;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic iv, input logic [WIDTH-1:0] din, input logic orr,
                      input logic fl, input logic e_rdy, input logic e_ov,
                      input logic [WIDTH-1:0] e_od, input int e_occ);
      vec_t v;
      v.rst = r; v.iv = iv; v.din = din; v.orr = orr; v.fl = fl;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
      vq.push_back(v);
   endtask

   task automatic chk_occ(input string nm, input int exp);
`ifdef PIPE_STAGE_REG_OCC_EN
      chk(nm, 32'(occupancy), 32'(exp));
`else
      if (exp < 0) $display("unused %s", nm);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int q[$];
      int exp_d;
      logic exp_rdy;

      // rst, iv, din, or, flush | in_ready(pre-edge), out_valid, out_data, occupancy (post-edge)
      // back-to-back stream, out_ready=1
      add(1, 1, 16'h0011, 1, 0, 1, 0, RV,       1);
      add(1, 1, 16'h0022, 1, 0, 1, 0, RV,       2);
      add(1, 1, 16'h0033, 1, 0, 1, 1, 16'h0011, 3);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h0022, 2);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h0033, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h0033, 0);
      // backpressure: fourth word waits, released same cycle as out_ready
      add(1, 1, 16'h0001, 0, 0, 1, 0, 16'h0033, 1);
      add(1, 1, 16'h0002, 0, 0, 1, 0, 16'h0033, 2);
      add(1, 1, 16'h0003, 0, 0, 1, 1, 16'h0001, 3);
      add(1, 1, 16'h0004, 0, 0, 0, 1, 16'h0001, 3);
      add(1, 1, 16'h0004, 1, 0, 1, 1, 16'h0002, 3);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h0003, 2);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h0004, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h0004, 0);
      // bubble collapse: A, bubble, B under 5 cycles of stall
      add(1, 1, 16'h00A1, 0, 0, 1, 0, 16'h0004, 1);
      add(1, 0, 16'h0000, 0, 0, 1, 0, 16'h0004, 1);
      add(1, 1, 16'h00B2, 0, 0, 1, 1, 16'h00A1, 2);
      add(1, 0, 16'h0000, 0, 0, 1, 1, 16'h00A1, 2);
      add(1, 0, 16'h0000, 0, 0, 1, 1, 16'h00A1, 2);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h00B2, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h00B2, 0);
      // fill, then flush with a same-cycle input transfer of 0xDEAD
      add(1, 1, 16'h00C1, 0, 0, 1, 0, 16'h00B2, 1);
      add(1, 1, 16'h00C2, 0, 0, 1, 0, 16'h00B2, 2);
      add(1, 1, 16'h00C3, 0, 0, 1, 1, 16'h00C1, 3);
      add(1, 1, 16'hDEAD, 1, 1, 1, 0, 16'h00C1, 0);
      add(1, 1, 16'h00E1, 1, 0, 1, 0, 16'h00C1, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h00C1, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h00E1, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h00E1, 0);
      // reset mid-stream with two valid stages, then clean restart
      add(1, 1, 16'h0051, 0, 0, 1, 0, 16'h00E1, 1);
      add(1, 1, 16'h0052, 0, 0, 1, 0, 16'h00E1, 2);
      add(0, 1, 16'h0053, 0, 0, 1, 0, RV,       0);
      add(1, 1, 16'h0061, 0, 0, 1, 0, RV,       1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, RV,       1);
      add(1, 0, 16'h0000, 1, 0, 1, 1, 16'h0061, 1);
      add(1, 0, 16'h0000, 1, 0, 1, 0, 16'h0061, 0);

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data", 32'(bus.out_data), 32'(RV));
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      chk_occ("reset occupancy", 0);

      foreach (vq[k]) begin
         rst           = vq[k].rst;
         bus.in_valid  = vq[k].iv;
         bus.in_data   = vq[k].din;
         bus.out_ready = vq[k].orr;
         flush         = vq[k].fl;
         #3;
         chk($sformatf("row%0d in_ready", k), 32'(bus.in_ready), 32'(vq[k].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("row%0d out_valid", k), 32'(bus.out_valid), 32'(vq[k].e_ov));
         chk($sformatf("row%0d out_data", k), 32'(bus.out_data), 32'(vq[k].e_od));
         chk_occ($sformatf("row%0d occupancy", k), vq[k].e_occ);
      end

      rst = 1'b1;
      flush = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = WIDTH'($urandom);
         bus.out_ready = ($urandom_range(0, 1) != 0);
         #3;
         exp_rdy = (q.size() < DEPTH) ? 1'b1 : bus.out_ready;
         chk("rand in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rand extra output: got 0x%0h expected none", bus.out_data);
            end else begin
               exp_d = q.pop_front();
               chk("rand out_data", 32'(bus.out_data), 32'(exp_d));
            end
         end
         if (bus.in_valid && bus.in_ready) q.push_back(int'(bus.in_data));
         @(posedge clk);
         #1;
         chk_occ("rand occupancy", q.size());
      end

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4 * DEPTH && q.size() > 0; c++) begin
         #3;
         if (bus.out_valid) begin
            exp_d = q.pop_front();
            chk("drain out_data", 32'(bus.out_data), 32'(exp_d));
         end
         @(posedge clk);
         #1;
      end
      chk("drain leftover payloads", 32'(q.size()), 32'd0);
      chk("drain out_valid", 32'(bus.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
